// File: rtl/ram_8x72_pkg.sv
// Shared widths and FSM state encoding for the 8x72 RAM controller and its flop-based RAM.
package ram_8x72_pkg;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 72;

   localparam logic [ADDR_W-1:0] LAST_ADDR = 3'd7;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_WR      = 3'd2,
      ST_RD      = 3'd3,
      ST_RD_WAIT = 3'd4,
      ST_RESP    = 3'd5
   } state_e;

endpackage

// File: rtl/dff_ram_8x72.sv
// 8-word x 72-bit flop RAM: active-low write strobe, registered read data one cycle after the address.
module dff_ram_8x72
   import ram_8x72_pkg::*;
(
   input  logic              clk,
   input  logic              ram_wr_n,
   input  logic [ADDR_W-1:0] ram_address,
   input  logic [DATA_W-1:0] ram_wdata,
   output logic [DATA_W-1:0] ram_rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Read-before-write array port.
   always_ff @(posedge clk) begin
      if (!ram_wr_n) begin
         mem_q[ram_address] <= ram_wdata;
      end
      rdata_q <= mem_q[ram_address];
   end

   assign ram_rdata = rdata_q;

endmodule

// File: rtl/ram_8x72_ctrl.sv
// Request/response controller for an 8x72 synchronous RAM with an optional post-reset clear.
module ram_8x72_ctrl
   import ram_8x72_pkg::*;
#(
   parameter int unsigned INIT_CLEAR = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              init_done,
   output logic              ram_wr_n,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              init_done_q;
   logic              ram_wr_n_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_q;

   // Controller FSM; every output is a flop updated together with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;
         cnt_q       <= 3'd0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 72'd0;
         init_done_q <= (INIT_CLEAR == 0);
         ram_wr_n_q  <= 1'b1;
         ram_addr_q  <= 3'd0;
         ram_wdata_q <= 72'd0;
      end else begin
         case (state_q)
            ST_INIT: begin
               // Leave only once the strobe for the last word has been presented.
               if (!ram_wr_n_q && (ram_addr_q == LAST_ADDR)) begin
                  ram_wr_n_q  <= 1'b1;
                  init_done_q <= 1'b1;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else begin
                  ram_wr_n_q  <= 1'b0;
                  ram_addr_q  <= cnt_q;
                  ram_wdata_q <= 72'd0;
                  if (cnt_q != LAST_ADDR) begin
                     cnt_q <= cnt_q + 3'd1;
                  end
               end
            end
            ST_IDLE: begin
               if (req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  ram_addr_q  <= req_addr;
                  if (req_write) begin
                     ram_wr_n_q  <= 1'b0;
                     ram_wdata_q <= req_wdata;
                     state_q     <= ST_WR;
                  end else begin
                     state_q <= ST_RD;
                  end
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            ST_WR: begin
               ram_wr_n_q  <= 1'b1;
               req_ready_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
            ST_RD: begin
               state_q <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               rsp_rdata_q <= ram_rdata;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               ram_wr_n_q  <= 1'b1;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign init_done   = init_done_q;
   assign ram_wr_n    = ram_wr_n_q;
   assign ram_address = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;

endmodule

// File: doc/ram_8x72_ctrl.md
RAM_8X72_CTRL -- requirements
Module: ram_8x72_ctrl

Interface
REQ-001 Parameter INIT_CLEAR, default 1, meaning: 1 = write zero to all 8 RAM words after reset; 0 = skip the clear.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  controller accepts a request this cycle.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  3  word address 0..7.
REQ-008 req_wdata  input  72  write data.
REQ-009 rsp_valid  output  1  read response present.
REQ-010 rsp_ready  input  1  consumer takes the response.
REQ-011 rsp_rdata  output  72  read data.
REQ-012 init_done  output  1  clear sequence finished; requests are now served.
REQ-013 ram_wr_n  output  1  RAM write strobe, active-low.
REQ-014 ram_address  output  3  RAM word address.
REQ-015 ram_wdata  output  72  RAM write data.
REQ-016 ram_rdata  input  72  RAM read data; valid in the cycle after ram_address is driven with ram_wr_n high.

Function
REQ-017 States SHALL be: INIT, IDLE, WR, RD, RD_WAIT, RESP.
REQ-018 INIT SHALL drive ram_wr_n=0 and ram_wdata=0, with ram_address stepping 0..7, one word per cycle (8 cycles total); the counter SHALL stop at 7 without wrapping.
REQ-019 INIT SHALL go to IDLE after the write to address 7; init_done SHALL rise in the first IDLE cycle and stay 1 until reset.
REQ-020 With INIT_CLEAR=0, the state after reset SHALL be IDLE and init_done SHALL be 1 from reset release.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-022 An accepted write SHALL go to WR for exactly one cycle: ram_wr_n=0, ram_address=req_addr, ram_wdata=req_wdata, all registered; the next state SHALL be IDLE.
REQ-023 An accepted read SHALL go to RD, where ram_address=req_addr and ram_wr_n=1.
REQ-024 RD_WAIT SHALL hold ram_address and capture ram_rdata into rsp_rdata on its closing edge.
REQ-025 The controller SHALL then enter RESP with rsp_valid=1; rsp_valid SHALL rise 3 cycles after the accept edge.
REQ-026 RESP SHALL hold rsp_valid and rsp_rdata stable until rsp_ready=1, then go to IDLE; rsp_valid SHALL be 0 in the next cycle.
REQ-027 ram_wr_n SHALL be 1 in every state except INIT and WR; ram_address and ram_wdata SHALL hold their last values when not being updated.
REQ-028 req_valid during INIT, WR, RD, RD_WAIT or RESP SHALL be ignored; the request SHALL NOT be consumed.
REQ-029 A read following a write to the same address SHALL return the newly written data.
REQ-030 Throughput SHALL be at most 1 write per 2 cycles and at most 1 read per 4 cycles (with rsp_ready held at 1).

Reset
REQ-031 While rst_n=0, outputs SHALL be: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0 (1 if INIT_CLEAR=0), ram_wr_n=1, ram_address=0, ram_wdata=0; the state SHALL be INIT (IDLE if INIT_CLEAR=0).
REQ-032 Reset asserted mid-operation (any state) SHALL discard the request in flight and any pending response, and SHALL rerun the clear when INIT_CLEAR=1.

Structure
REQ-033 Shared package ram_8x72_pkg SHALL hold DEPTH=8, ADDR_W=3, DATA_W=72 and the state enumeration; the same widths SHALL size dff_ram_8x72.
REQ-034 No sub-module; a single FSM with a 3-bit init counter SHALL implement the block.
REQ-035 The bench SHALL connect ram_* directly to a dff_ram_8x72 instance.

Verification
REQ-036 Reset release, INIT_CLEAR=1 -> 8 consecutive cycles with ram_wr_n=0 at addresses 0..7 and data 0; init_done=1 on cycle 9; reads of all addresses return 0.
REQ-037 Write addr 5 = 72'hAB_CDEF_0123_4567_89AB, then read addr 5, rsp_ready=1 -> rsp_valid 3 cycles after the accept edge, rsp_rdata=72'hAB_CDEF_0123_4567_89AB.
REQ-038 Read addr 2 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held stable, req_ready=0 throughout; single handshake on rsp_ready=1, then IDLE.
REQ-039 req_valid=1 asserted during INIT -> no accept until init_done=1; the request is then accepted in the first IDLE cycle.
REQ-040 rst_n pulsed low during RD_WAIT -> rsp_valid never asserts, all outputs take their reset values immediately, and the clear sequence reruns.
REQ-041 Back-to-back writes to addresses 7, 0, 7 with distinct data, then reads of 7 and 0 -> the last-written values return, and each write shows exactly one ram_wr_n=0 cycle.
